cache_miss_handler: RTL and testbench

//  Memory-side counterpart of the per-set lookup/replacement logic. On a lookup miss it writes

---
 rtl/cache_miss_handler_pkg.sv | 27 ++
 rtl/cache_miss_handler_if.sv | 45 ++++
 rtl/cache_miss_handler_line_word_counter.sv | 30 +++
 rtl/cache_miss_handler.sv | 148 ++++++++++++++
 tb/tb_cache_miss_handler.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_miss_handler_pkg.sv
// Shared types and helpers for the cache miss handler: FSM state enum, default geometry,
// line-size arithmetic and address field slicing.
package cache_miss_handler_pkg;
    localparam int DEF_TAG_WIDTH    = 24;
    localparam int DEF_SET_WIDTH    = 4;
    localparam int DEF_OFFSET_WIDTH = 4;
    localparam int DEF_WAYS         = 4;

    typedef enum logic [1:0] {
        IDLE,
        WB,
        FILL,
        DONE
    } miss_state_t;

    function automatic int words_per_line(input int offset_width);
        return 1 << (offset_width - 2);
    endfunction

    function automatic logic [31:0] line_tag_set(input logic [31:0] addr, input int offset_width);
        return addr >> offset_width;
    endfunction

    function automatic logic [31:0] word_index(input logic [31:0] addr, input int offset_width);
        return (addr >> 2) & ((32'd1 << (offset_width - 2)) - 32'd1);
    endfunction
endpackage

// File: rtl/cache_miss_handler_if.sv
// Core request, set-array and memory-bus signals of the cache miss handler.
// The master side is the miss handler, the slave side is the cache arrays plus memory.
interface cache_miss_handler_if #(
    parameter int TAG_WIDTH    = cache_miss_handler_pkg::DEF_TAG_WIDTH,
    parameter int OFFSET_WIDTH = cache_miss_handler_pkg::DEF_OFFSET_WIDTH,
    parameter int WAYS         = cache_miss_handler_pkg::DEF_WAYS
);
    localparam int WAY_W = $clog2(WAYS);
    localparam int WW    = OFFSET_WIDTH - 2;

    logic                 req_valid;
    logic [31:0]          req_addr;
    logic                 hit;
    logic                 dirty;
    logic [TAG_WIDTH-1:0] replace_tag;
    logic [WAY_W-1:0]     victim_way;
    logic [31:0]          line_rdata;
    logic [WAY_W-1:0]     line_way;
    logic [WW-1:0]        line_word;
    logic [31:0]          line_wdata;
    logic                 line_we;
    logic                 line_fill;
    logic                 victim_adv;
    logic                 stall;
    logic                 mem_req;
    logic                 mem_we;
    logic [31:0]          mem_addr;
    logic [31:0]          mem_wdata;
    logic [31:0]          mem_rdata;
    logic                 mem_ready;

    modport master (
        input  req_valid, req_addr, hit, dirty, replace_tag, victim_way, line_rdata,
               mem_rdata, mem_ready,
        output line_way, line_word, line_wdata, line_we, line_fill, victim_adv, stall,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output req_valid, req_addr, hit, dirty, replace_tag, victim_way, line_rdata,
               mem_rdata, mem_ready,
        input  line_way, line_word, line_wdata, line_we, line_fill, victim_adv, stall,
               mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cache_miss_handler_line_word_counter.sv
// Word counter shared by the writeback and refill phases: loadable start word,
// wrapping increment, and a flag marking the last word of a full-line burst.
module line_word_counter #(
    parameter int WW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [WW-1:0] load_val,
    input  logic          inc,
    output logic [WW-1:0] cnt,
    output logic          last
);
    logic [WW-1:0] start_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            start_q <= '0;
        end else if (load) begin
            cnt     <= load_val;
            start_q <= load_val;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    // A burst ends on the word just before its start, so a wrapped burst still moves a full line.
    assign last = (cnt + 1'b1) == start_q;
endmodule

// File: rtl/cache_miss_handler.sv
// Cache miss handler: writes back a dirty victim line, refills it from memory, stalls the core.
// Build option CACHE_CRITICAL_WORD_EN: refill starts at the requested word and stall drops early.
module cache_miss_handler
    import cache_miss_handler_pkg::*;
#(
    parameter int TAG_WIDTH    = DEF_TAG_WIDTH,
    parameter int SET_WIDTH    = DEF_SET_WIDTH,
    parameter int OFFSET_WIDTH = DEF_OFFSET_WIDTH,
    parameter int WAYS         = DEF_WAYS
) (
    input logic                  clk,
    input logic                  reset,
    cache_miss_handler_if.master bus
);
    localparam int WW    = OFFSET_WIDTH - 2;
    localparam int WAY_W = $clog2(WAYS);
    localparam int TS_W  = TAG_WIDTH + SET_WIDTH;

    miss_state_t          state, state_nxt;
    logic [TS_W-1:0]      tag_set_q, req_tag_set;
    logic [TAG_WIDTH-1:0] vtag_q;
    logic [WAY_W-1:0]     way_q;
    logic [WW-1:0]        fill_start_q, fill_start_in;
    logic [WW-1:0]        cnt, cnt_load_val;
    logic                 cnt_load, cnt_inc, cnt_last;
    logic                 miss, fill_stall;
    logic                 unused_offset_bits;

    assign miss               = bus.req_valid & ~bus.hit;
    assign req_tag_set        = TS_W'(line_tag_set(bus.req_addr, OFFSET_WIDTH));
    assign unused_offset_bits = ^bus.req_addr[OFFSET_WIDTH-1:0];

`ifdef CACHE_CRITICAL_WORD_EN
    logic crit_seen_q;

    assign fill_start_in = WW'(word_index(bus.req_addr, OFFSET_WIDTH));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            crit_seen_q <= 1'b0;
        else if (state == IDLE)
            crit_seen_q <= 1'b0;
        else if (state == FILL && bus.mem_ready && cnt == fill_start_q)
            crit_seen_q <= 1'b1;
    end

    // Once the requested word is in the array the core runs on; only a miss to another line waits.
    assign fill_stall = ~crit_seen_q | (miss & (req_tag_set != tag_set_q));
`else
    assign fill_start_in = '0;
    assign fill_stall    = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            tag_set_q    <= '0;
            vtag_q       <= '0;
            way_q        <= '0;
            fill_start_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && miss) begin
                tag_set_q    <= req_tag_set;
                vtag_q       <= bus.replace_tag;
                way_q        <= bus.victim_way;
                fill_start_q <= fill_start_in;
            end
        end
    end

    line_word_counter #(.WW(WW)) u_word_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .inc      (cnt_inc),
        .cnt      (cnt),
        .last     (cnt_last)
    );

    always_comb begin
        state_nxt      = state;
        cnt_load       = 1'b0;
        cnt_load_val   = '0;
        cnt_inc        = 1'b0;
        bus.stall      = 1'b0;
        bus.line_way   = '0;
        bus.line_word  = '0;
        bus.line_wdata = '0;
        bus.line_we    = 1'b0;
        bus.line_fill  = 1'b0;
        bus.victim_adv = 1'b0;
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        case (state)
            IDLE: begin
                if (miss) begin
                    bus.stall    = ~reset;
                    cnt_load     = 1'b1;
                    cnt_load_val = bus.dirty ? '0 : fill_start_in;
                    state_nxt    = bus.dirty ? WB : FILL;
                end
            end
            WB: begin
                bus.stall     = 1'b1;
                bus.line_way  = way_q;
                bus.line_word = cnt;
                bus.mem_req   = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = {vtag_q, tag_set_q[SET_WIDTH-1:0], cnt, 2'b00};
                bus.mem_wdata = bus.line_rdata;
                if (bus.mem_ready) begin
                    if (cnt_last) begin
                        cnt_load     = 1'b1;
                        cnt_load_val = fill_start_q;
                        state_nxt    = FILL;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            FILL: begin
                bus.stall     = fill_stall;
                bus.line_way  = way_q;
                bus.line_word = cnt;
                bus.mem_req   = 1'b1;
                bus.mem_addr  = {tag_set_q, cnt, 2'b00};
                if (bus.mem_ready) begin
                    bus.line_we    = 1'b1;
                    bus.line_wdata = bus.mem_rdata;
                    cnt_inc        = 1'b1;
                    if (cnt_last)
                        state_nxt = DONE;
                end
            end
            DONE: begin
                bus.line_way   = way_q;
                bus.line_fill  = 1'b1;
                bus.victim_adv = 1'b1;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_cache_miss_handler.sv
// Self-checking bench for cache_miss_handler: each miss is predicted as a list of bus
// transfers and line writes, then compared cycle by cycle against the design.
module tb_cache_miss_handler;
    localparam int WORDS = 4;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } bus_op_t;

    typedef struct packed {
        logic [1:0]  word;
        logic [31:0] data;
    } line_op_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          total = 0;
    int          bad = 0;
    logic [31:0] victim_line [WORDS];
    logic [31:0] salt = 32'h0;
    bit          crit_mode = 1'b0;
    bus_op_t     exp_bus[$];
    line_op_t    exp_line[$];

    cache_miss_handler_if bus ();
    cache_miss_handler dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // Victim array and memory are behavioural: array word per index, memory returns addr^salt.
    assign bus.line_rdata = victim_line[bus.line_word];
    assign bus.mem_rdata  = bus.mem_addr ^ salt;

    task automatic build_model(input logic [31:0] addr, input logic dirty, input logic [23:0] rtag);
        int          start;
        logic [31:0] a;
        exp_bus.delete();
        exp_line.delete();
        if (dirty)
            for (int w = 0; w < WORDS; w++)
                exp_bus.push_back('{1'b1, {rtag, addr[7:4], 4'h0} + 32'(w * 4), victim_line[w]});
        start = crit_mode ? int'((addr % 32'd16) / 32'd4) : 0;
        for (int k = 0; k < WORDS; k++) begin
            a = (addr & 32'hFFFF_FFF0) + 32'(((start + k) % WORDS) * 4);
            exp_bus.push_back('{1'b0, a, 32'h0});
            exp_line.push_back('{2'((start + k) % WORDS), a ^ salt});
        end
    endtask

    task automatic do_miss(input string name, input logic [31:0] addr, input logic dirty,
                           input logic [23:0] rtag, input logic [1:0] way,
                           input int ready_mode, input bit garble);
        int       cyc = 0;
        bit       done = 1'b0;
        bit       crit_written = 1'b0;
        bit       in_done;
        logic     exp_stall;
        bus_op_t  op;
        line_op_t lop;
        for (int w = 0; w < WORDS; w++) victim_line[w] = $urandom;
        salt = $urandom;
        build_model(addr, dirty, rtag);
        while (!done && cyc < 200) begin
            @(negedge clk);
            if (cyc == 0) begin
                bus.req_valid   = 1'b1;
                bus.hit         = 1'b0;
                bus.req_addr    = addr;
                bus.dirty       = dirty;
                bus.replace_tag = rtag;
                bus.victim_way  = way;
            end else if (garble) begin
                bus.replace_tag = 24'($urandom);
                bus.victim_way  = 2'($urandom);
                bus.dirty       = 1'($urandom);
                if (!crit_mode) bus.req_addr = $urandom;
            end
            case (ready_mode)
                0:       bus.mem_ready = 1'b1;
                1:       bus.mem_ready = 1'($urandom_range(0, 1));
                default: bus.mem_ready = cyc[0];
            endcase
            #1;
            in_done   = (cyc > 0) && (exp_bus.size() == 0);
            exp_stall = in_done ? 1'b0 : !crit_written;
            total++;
            if (bus.stall !== exp_stall) begin
                bad++;
                $display("FAIL %s stall cyc=%0d: got %b want %b", name, cyc, bus.stall, exp_stall);
            end
            total++;
            if (bus.line_fill !== in_done || bus.victim_adv !== in_done) begin
                bad++;
                $display("FAIL %s fill_pulse cyc=%0d: got fill=%b adv=%b want %b", name, cyc,
                         bus.line_fill, bus.victim_adv, in_done);
            end
            if (cyc == 0) begin
                total++;
                if (bus.mem_req !== 1'b0) begin
                    bad++;
                    $display("FAIL %s accept_mem_req: got %b want 0", name, bus.mem_req);
                end
            end else if (in_done) begin
                done = 1'b1;
                total++;
                if (bus.line_way !== way || bus.mem_req !== 1'b0) begin
                    bad++;
                    $display("FAIL %s done_way: got way=%0d req=%b want way=%0d req=0", name,
                             bus.line_way, bus.mem_req, way);
                end
                if (ready_mode == 0) begin
                    total++;
                    if (cyc != (dirty ? 2 * WORDS + 1 : WORDS + 1)) begin
                        bad++;
                        $display("FAIL %s latency: got %0d want %0d", name, cyc,
                                 dirty ? 2 * WORDS + 1 : WORDS + 1);
                    end
                end
            end else begin
                op = exp_bus[0];
                total++;
                if (bus.mem_req !== 1'b1 || bus.mem_we !== op.we || bus.mem_addr !== op.addr) begin
                    bad++;
                    $display("FAIL %s bus_addr cyc=%0d: got req=%b we=%b addr=%h want req=1 we=%b addr=%h",
                             name, cyc, bus.mem_req, bus.mem_we, bus.mem_addr, op.we, op.addr);
                end
                total++;
                if (bus.line_way !== way) begin
                    bad++;
                    $display("FAIL %s line_way cyc=%0d: got %0d want %0d", name, cyc, bus.line_way, way);
                end
                if (op.we) begin
                    total++;
                    if (bus.mem_wdata !== op.data) begin
                        bad++;
                        $display("FAIL %s wb_data cyc=%0d: got %h want %h", name, cyc, bus.mem_wdata, op.data);
                    end
                end
                if (bus.mem_ready && !op.we) begin
                    void'(exp_bus.pop_front());
                    lop = exp_line.pop_front();
                    total++;
                    if (bus.line_we !== 1'b1 || bus.line_word !== lop.word || bus.line_wdata !== lop.data) begin
                        bad++;
                        $display("FAIL %s refill cyc=%0d: got we=%b word=%0d data=%h want we=1 word=%0d data=%h",
                                 name, cyc, bus.line_we, bus.line_word, bus.line_wdata, lop.word, lop.data);
                    end
                    crit_written = crit_mode;
                end else begin
                    if (bus.mem_ready) void'(exp_bus.pop_front());
                    total++;
                    if (bus.line_we !== 1'b0) begin
                        bad++;
                        $display("FAIL %s line_we_idle cyc=%0d: got %b want 0", name, cyc, bus.line_we);
                    end
                end
            end
            cyc++;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s timeout: no line_fill after %0d cycles, %0d transfers left", name, cyc,
                     exp_bus.size());
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            bus.mem_ready = 1'($urandom_range(0, 1));
            #1;
            total++;
            if (bus.stall !== 1'b0 || bus.mem_req !== 1'b0 || bus.line_fill !== 1'b0) begin
                bad++;
                $display("FAIL idle: got stall=%b req=%b fill=%b want 0 0 0", bus.stall, bus.mem_req,
                         bus.line_fill);
            end
        end
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b0; bus.req_addr = '0; bus.hit = 1'b0; bus.dirty = 1'b0;
        bus.replace_tag = '0; bus.victim_way = '0; bus.mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if ({bus.stall, bus.mem_req, bus.mem_we, bus.line_we, bus.line_fill, bus.victim_adv} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {bus.stall, bus.mem_req, bus.mem_we, bus.line_we, bus.line_fill, bus.victim_adv});
        end
        total++;
        if (bus.mem_addr !== 32'h0 || bus.line_word !== 2'd0 || bus.line_way !== 2'd0) begin
            bad++;
            $display("FAIL reset_data: got addr=%h word=%0d way=%0d want 0", bus.mem_addr,
                     bus.line_word, bus.line_way);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_hit();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.req_valid = 1'b1;
            bus.hit       = 1'b1;
            bus.req_addr  = $urandom;
            bus.dirty     = 1'($urandom);
            bus.mem_ready = 1'($urandom);
            #1;
            total++;
            if (bus.stall !== 1'b0 || bus.mem_req !== 1'b0 || bus.line_fill !== 1'b0) begin
                bad++;
                $display("FAIL hit: got stall=%b req=%b fill=%b want 0 0 0", bus.stall, bus.mem_req,
                         bus.line_fill);
            end
        end
        bus.hit       = 1'b0;
        bus.req_valid = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            do_miss("random", $urandom, 1'($urandom), 24'($urandom), 2'($urandom),
                    int'($urandom_range(0, 2)), 1'b1);
            if (i % 3 == 0) idle(1);
        end
        idle(2);
    endtask

    task automatic test_back_to_back();
        do_miss("b2b_first", 32'h0000_5A30, 1'b1, 24'h000777, 2'd3, 0, 1'b0);
        do_miss("b2b_second", 32'h0000_1270, 1'b0, 24'h000012, 2'd1, 0, 1'b0);
        test_hit();
        idle(1);
    endtask

    task automatic test_reset_mid_fill();
        salt = $urandom;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.hit = 1'b0; bus.req_addr = 32'h0000_0100;
        bus.dirty = 1'b0; bus.victim_way = 2'd2; bus.mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0000_0108) begin
            bad++;
            $display("FAIL rst_mid_pre: got req=%b addr=%h want req=1 addr=00000108", bus.mem_req,
                     bus.mem_addr);
        end
        reset = 1'b1;
        #1;
        total++;
        if (bus.mem_req !== 1'b0 || bus.line_fill !== 1'b0 || bus.stall !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_abort: got req=%b fill=%b stall=%b want 0 0 0", bus.mem_req,
                     bus.line_fill, bus.stall);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        reset = 1'b0;
        idle(4);
    endtask

    initial begin
`ifdef CACHE_CRITICAL_WORD_EN
        crit_mode = 1'b1;
`endif
        test_reset();
        test_hit();
        do_miss("clean_miss", 32'h0000_0100, 1'b0, 24'h000001, 2'd1, 0, 1'b0);
        idle(1);
        do_miss("dirty_miss", 32'h0000_0230, 1'b1, 24'h00ABCD, 2'd2, 0, 1'b0);
        idle(1);
        do_miss("ready_toggle", 32'h0001_2340, 1'b1, 24'h00BEEF, 2'd3, 2, 1'b1);
        idle(1);
        do_miss("critical_word", 32'h0000_0108, 1'b0, 24'h000001, 2'd0, 0, 1'b0);
        idle(1);
        test_random();
        test_back_to_back();
        test_reset_mid_fill();
        do_miss("after_reset", 32'h0000_0100, 1'b1, 24'h000042, 2'd1, 0, 1'b0);
        idle(1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
